// File: rtl/ccta_pkg.sv
// Shared constants and state encoding for the CCTA scheduler slice.
package ccta_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned Q_W   = 5;
    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ccta_state_t;

endpackage

// File: rtl/ccta_sched_if.sv
// Request, result and datapath signal bundle between requesters, scheduler and CCTA.
interface ccta_sched_if;
    import ccta_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_a;
    logic [N_REQ*OP_W-1:0] req_b;
    logic [N_REQ*OP_W-1:0] req_c;
    logic [N_REQ-1:0]      req_op;

    logic [OP_W-1:0]       dp_a;
    logic [OP_W-1:0]       dp_b;
    logic [OP_W-1:0]       dp_c;
    logic                  dp_ctrl;
    logic                  dp_rst;
    logic [Q_W-1:0]        dp_q;

    logic                  res_valid;
    logic                  res_ready;
    logic [Q_W-1:0]        res_q;
    logic                  res_id;
    logic                  busy;

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, req_c, req_op, dp_q, res_ready,
        output req_ready, dp_a, dp_b, dp_c, dp_ctrl, dp_rst,
        output res_valid, res_q, res_id, busy
    );

    // Requester / consumer / datapath side.
    modport master (
        output req_valid, req_a, req_b, req_c, req_op, dp_q, res_ready,
        input  req_ready, dp_a, dp_b, dp_c, dp_ctrl, dp_rst,
        input  res_valid, res_q, res_id, busy
    );

endinterface

// File: rtl/ccta_rr_arb.sv
// Two-port round-robin grant: a lone requester wins, a tie goes to prio.
module ccta_rr_arb (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] gnt
);

    // One-hot grant, or zero when disabled or nobody requests.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = prio ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/ccta_sched.sv
// Sequencer for the shared CCTA datapath: arbitrates two requesters, holds the
// granted operands for SETTLE cycles, captures q and returns it with the id.
module ccta_sched
    import ccta_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ccta_sched_if.slave  io_bus
);

    ccta_state_t     r_state;
    logic            r_prio;
    logic [3:0]      r_cnt;
    logic            r_cur_id;
    logic [OP_W-1:0] r_dp_a;
    logic [OP_W-1:0] r_dp_b;
    logic [OP_W-1:0] r_dp_c;
    logic            r_dp_ctrl;
    logic            r_dp_rst;
    logic            r_res_valid;
    logic [Q_W-1:0]  r_res_q;
    logic            r_res_id;

    logic [1:0]      w_gnt;
    logic            w_en;
    logic            w_sel;
    logic            w_accept;
    logic [OP_W-1:0] w_sel_a;
    logic [OP_W-1:0] w_sel_b;
    logic [OP_W-1:0] w_sel_c;
    logic            w_sel_op;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign w_en = (r_state == IDLE) && rst_n;

    ccta_rr_arb u_arb (
        .req  (io_bus.req_valid),
        .prio (r_prio),
        .en   (w_en),
        .gnt  (w_gnt)
    );

    // Pick the operand slot of the granted requester.
    always_comb begin
        w_sel    = w_gnt[1];
        w_accept = |(io_bus.req_valid & w_gnt);
        if (w_sel) begin
            w_sel_a  = io_bus.req_a[2*OP_W-1:OP_W];
            w_sel_b  = io_bus.req_b[2*OP_W-1:OP_W];
            w_sel_c  = io_bus.req_c[2*OP_W-1:OP_W];
            w_sel_op = io_bus.req_op[1];
        end else begin
            w_sel_a  = io_bus.req_a[OP_W-1:0];
            w_sel_b  = io_bus.req_b[OP_W-1:0];
            w_sel_c  = io_bus.req_c[OP_W-1:0];
            w_sel_op = io_bus.req_op[0];
        end
    end

    // FSM with all registered outputs; dp_rst trails rst_n by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_cnt       <= 4'd0;
            r_cur_id    <= 1'b0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_c      <= '0;
            r_dp_ctrl   <= 1'b0;
            r_dp_rst    <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_q     <= '0;
            r_res_id    <= 1'b0;
        end else begin
            r_dp_rst <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dp_a    <= w_sel_a;
                        r_dp_b    <= w_sel_b;
                        r_dp_c    <= w_sel_c;
                        r_dp_ctrl <= w_sel_op;
                        r_cur_id  <= w_sel;
                        r_cnt     <= 4'(SETTLE - 1);
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_res_q     <= io_bus.dp_q;
                        r_res_id    <= r_cur_id;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (io_bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_prio      <= ~r_cur_id;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.req_ready = w_gnt;
    assign io_bus.dp_a      = r_dp_a;
    assign io_bus.dp_b      = r_dp_b;
    assign io_bus.dp_c      = r_dp_c;
    assign io_bus.dp_ctrl   = r_dp_ctrl;
    assign io_bus.dp_rst    = r_dp_rst;
    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_q     = r_res_q;
    assign io_bus.res_id    = r_res_id;
    assign io_bus.busy      = (r_state != IDLE);

endmodule
